// File: rtl/inta_sequencer_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package inta_seq_pkg;

  // Sequencer phases, from INT detection through the EOI write-back.
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ACK1       = 4'd1,
    GAP        = 4'd2,
    ACK2       = 4'd3,
    PRESENT    = 4'd4,
    SERVICE    = 4'd5,
    EOI_SETUP  = 4'd6,
    EOI_STROBE = 4'd7,
    EOI_HOLD   = 4'd8
  } state_t;

  // OCW2 command bytes: non-specific and specific end-of-interrupt.
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;
  localparam logic [7:0] OCW2_SP_EOI = 8'h60;

  // Low three vector bits select the IR level for a specific EOI.
  localparam logic [2:0] EOI_LEVEL_MASK = 3'b111;

endpackage

// File: rtl/inta_sequencer_strobe_timer.sv
// Loadable down-counter timing the INTA low, INTA gap and WR low phases.
// done is high in the last cycle of a loaded interval, so a phase loaded
// with N lasts exactly N cycles.
module strobe_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on demand, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/inta_sequencer.sv
// Host-side 8259A INT/INTA sequencer: two INTA pulses, vector capture,
// valid/ready hand-off to the core, then an OCW2 EOI write.
// Build option: INTA_SEQ_SPECIFIC_EOI_EN selects a specific EOI (0x60|level)
// instead of the non-specific EOI (0x20).
//
// Handshake: vec_valid rises with a stable vec_out and stays high, with
// vec_out unchanged, until an edge samples vec_ready high; that edge is the
// transfer and vec_valid drops after it. vec_ready without vec_valid is a no-op.
module inta_sequencer
  import inta_seq_pkg::*;
#(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic       int_enable,
  output logic       inta_n,
  input  logic [7:0] data_in,
  output logic [7:0] vec_out,
  output logic       vec_valid,
  input  logic       vec_ready,
  input  logic       eoi_req,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       eoi_done,
  output logic       busy,
  output state_t     dbg_state
);

  localparam int MAX_CYC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES
                                                               : INTA_GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LOW_CNT = CW'(INTA_LOW_CYCLES);
  localparam logic [CW-1:0] GAP_CNT = CW'(INTA_GAP_CYCLES);

  state_t          state;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_done;
  logic [7:0]      eoi_cmd;

  assign dbg_state = state;

`ifdef INTA_SEQ_SPECIFIC_EOI_EN
  assign eoi_cmd = OCW2_SP_EOI | {5'b0, vec_out[2:0] & EOI_LEVEL_MASK};
`else
  assign eoi_cmd = OCW2_NS_EOI;
`endif

  strobe_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Reload the timer on every state change with the next phase's length.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:       if (int_req && int_enable) begin tmr_load = 1'b1; tmr_val = LOW_CNT; end
      ACK1:       if (tmr_done) begin tmr_load = 1'b1; tmr_val = GAP_CNT; end
      GAP:        if (tmr_done) begin tmr_load = 1'b1; tmr_val = LOW_CNT; end
      ACK2:       if (tmr_done) tmr_load = 1'b1;
      PRESENT:    if (vec_ready) tmr_load = 1'b1;
      SERVICE:    if (eoi_req) tmr_load = 1'b1;
      EOI_SETUP:  begin tmr_load = 1'b1; tmr_val = LOW_CNT; end
      EOI_STROBE: if (tmr_done) tmr_load = 1'b1;
      EOI_HOLD:   tmr_load = 1'b1;
      default:    tmr_load = 1'b0;
    endcase
  end

  // Sequencer FSM; every output is registered and updated with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      inta_n    <= 1'b1;
      wr_n      <= 1'b1;
      a0        <= 1'b0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      vec_out   <= 8'h00;
      vec_valid <= 1'b0;
      eoi_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      eoi_done <= 1'b0;
      case (state)
        IDLE: begin
          if (int_req && int_enable) begin
            state  <= ACK1;
            inta_n <= 1'b0;
            busy   <= 1'b1;
          end
        end
        ACK1: begin
          if (tmr_done) begin
            state  <= GAP;
            inta_n <= 1'b1;
          end
        end
        GAP: begin
          if (tmr_done) begin
            state  <= ACK2;
            inta_n <= 1'b0;
          end
        end
        ACK2: begin
          // The controller drives the vector during the second pulse.
          if (tmr_done) begin
            state     <= PRESENT;
            inta_n    <= 1'b1;
            vec_out   <= data_in;
            vec_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (vec_ready) begin
            state     <= SERVICE;
            vec_valid <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi_req) begin
            state    <= EOI_SETUP;
            data_oe  <= 1'b1;
            a0       <= 1'b0;
            data_out <= eoi_cmd;
          end
        end
        EOI_SETUP: begin
          state <= EOI_STROBE;
          wr_n  <= 1'b0;
        end
        EOI_STROBE: begin
          if (tmr_done) begin
            state <= EOI_HOLD;
            wr_n  <= 1'b1;
          end
        end
        EOI_HOLD: begin
          // Data held one cycle past WR rising edge, then bus released.
          state    <= IDLE;
          data_oe  <= 1'b0;
          data_out <= 8'h00;
          eoi_done <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          inta_n    <= 1'b1;
          wr_n      <= 1'b1;
          data_oe   <= 1'b0;
          vec_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Host-side interrupt acknowledge sequencer: the CPU end of the 8259A INT/INTA handshake. It detects INT from the interrupt controller and drives the two-pulse INTA sequence. It latches the vector byte the controller places on the data bus during the second pulse, hands the vector to the core over a valid/ready handshake, and writes the OCW2 end-of-interrupt command back to the controller when the core finishes service.

## Interface
Parameters:
- INTA_LOW_CYCLES, 2, cycles each INTA and WR strobe is held low (>=1)
- INTA_GAP_CYCLES, 1, cycles INTA is high between the two pulses (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- int_req  in  1  INT from interrupt controller, same clock domain
- int_enable  in  1  core interrupt-enable flag (IF)
- inta_n  out  1  active-low acknowledge strobe to controller
- data_in  in  8  controller data bus, valid during second INTA pulse
- vec_out  out  8  latched interrupt vector
- vec_valid  out  1  vec_out valid
- vec_ready  in  1  core accepts vector
- eoi_req  in  1  single-cycle pulse: core has finished the service routine
- wr_n  out  1  active-low write strobe to controller
- a0  out  1  controller address bit, always 0 during EOI write
- data_out  out  8  OCW2 command byte
- data_oe  out  1  data_out drives the bus
- eoi_done  out  1  one-cycle pulse when the EOI write completes
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACK1, GAP, ACK2, PRESENT, SERVICE, EOI_SETUP, EOI_STROBE, EOI_HOLD.
- IDLE: int_req & int_enable sampled high -> ACK1. No other transition.
- ACK1: inta_n=0 for INTA_LOW_CYCLES cycles -> GAP.
- GAP: inta_n=1 for INTA_GAP_CYCLES cycles -> ACK2.
- ACK2: inta_n=0 for INTA_LOW_CYCLES cycles. data_in is registered into vec_out on the final edge -> PRESENT.
- PRESENT: vec_valid=1 and vec_out stable until vec_ready=1. Transfer on the same edge -> SERVICE.
- SERVICE: wait for eoi_req -> EOI_SETUP.
- EOI_SETUP: data_oe=1, a0=0, data_out=command, for 1 cycle -> EOI_STROBE.
- EOI_STROBE: wr_n=0 for INTA_LOW_CYCLES cycles -> EOI_HOLD.
- EOI_HOLD: wr_n=1, data_oe=1 for 1 cycle. Then eoi_done=1 for 1 cycle, data_oe=0 -> IDLE.
- Once the sequence leaves IDLE it runs to completion. int_req or int_enable dropping mid-sequence is ignored.
- eoi_req outside SERVICE is ignored and not queued.
- int_req held high after EOI starts a new sequence only after IDLE is re-entered.
- Internal cycle counter is $clog2(max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)+1) bits wide. It reloads on every state entry.
- All outputs are registered.

## Timing
- Reset values: inta_n=1, wr_n=1, a0=0, data_out=0, data_oe=0, vec_out=0, vec_valid=0, eoi_done=0, busy=0, state=IDLE.
- Reset mid-sequence aborts the sequence immediately (asynchronously): strobes go high and the bus is released.
- Detection at edge 0: inta_n is low after edges 0..L-1, high for G cycles, then low for L cycles. vec_valid rises at edge 2L+G (L=2, G=1 -> edge 5).
- vec_valid falls on the edge where vec_valid & vec_ready.
- eoi_req at edge e: data_oe rises after e. wr_n is low after edges e+1..e+L. eoi_done is high and data_oe falls after edge e+L+2.
- The earliest re-detection of int_req is edge e+L+3.

## Configuration
- INTA_SEQ_SPECIFIC_EOI_EN defined: data_out = 8'h60 | {5'b0, vec_out[2:0]} (specific EOI for the serviced level).
- Undefined: data_out = 8'h20 (non-specific EOI).
- No other behaviour differs.

## Structure
- Package inta_seq_pkg:
  - state enum
  - OCW2_NS_EOI=8'h20
  - OCW2_SP_EOI=8'h60
  - EOI level mask 3'b111
- Sub-module strobe_timer: loadable down-counter with a done flag, shared by the ACK, GAP and EOI_STROBE phases.

## Test plan
- Reset, int_req=1, int_enable=1, data_in=8'h4B, L=2/G=1 -> inta_n low cycles 1-2 and 4-5, vec_valid at cycle 5 with vec_out=8'h4B, busy=1.
- int_req=1 with int_enable=0 for 20 cycles -> inta_n stays 1, busy=0.
- vec_ready held low 10 cycles, then pulsed -> vec_out stable and vec_valid high throughout, drops the cycle after acceptance.
- eoi_req in SERVICE, vector 8'h4B -> wr_n low 2 cycles, a0=0, data_out=8'h20 (8'h63 with INTA_SEQ_SPECIFIC_EOI_EN), eoi_done pulse, data_oe released.
- eoi_req pulsed in PRESENT, then vec_ready -> no write occurs, state remains SERVICE.
- reset asserted during ACK2 -> inta_n=1, vec_valid=0 immediately. Next int_req restarts from ACK1.
